// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types and constants for the multicycle core control
//                FSM: state encodings, per-state datapath control vectors and
//                the wait-timer width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        EXECUTEL = 4'd10,
        FAULT    = 4'd11
    } state_t;

    localparam int CTRL_W = 13;

    // Bit positions inside the control vector
    // {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    localparam int c_bit_nextpc  = 12;
    localparam int c_bit_branch  = 11;
    localparam int c_bit_memw    = 10;
    localparam int c_bit_regw    = 9;
    localparam int c_bit_irwrite = 8;

    localparam logic [CTRL_W-1:0] c_ctrl_fetch  = 13'b1000101001100;
    localparam logic [CTRL_W-1:0] c_ctrl_decode = 13'b0000001001100;
    localparam logic [CTRL_W-1:0] c_ctrl_execr  = 13'b0000000000001;
    localparam logic [CTRL_W-1:0] c_ctrl_execi  = 13'b0000000000011;
    localparam logic [CTRL_W-1:0] c_ctrl_aluwb  = 13'b0001000000000;
    localparam logic [CTRL_W-1:0] c_ctrl_memadr = 13'b0000000000010;
    localparam logic [CTRL_W-1:0] c_ctrl_memrd  = 13'b0000010000000;
    localparam logic [CTRL_W-1:0] c_ctrl_memwr  = 13'b0010010000000;
    localparam logic [CTRL_W-1:0] c_ctrl_memwb  = 13'b0001000100000;
    localparam logic [CTRL_W-1:0] c_ctrl_branch = 13'b0100001000010;

    // Ungated control vector for a state; unknown encodings and FAULT drive all zeros
    function automatic logic [CTRL_W-1:0] ctrl_for_state(input state_t s);
        logic [CTRL_W-1:0] v;
        v = '0;
        case (s)
            FETCH:              v = c_ctrl_fetch;
            DECODE:             v = c_ctrl_decode;
            EXECUTER, EXECUTEL: v = c_ctrl_execr;
            EXECUTEI:           v = c_ctrl_execi;
            ALUWB:              v = c_ctrl_aluwb;
            MEMADR:             v = c_ctrl_memadr;
            MEMRD:              v = c_ctrl_memrd;
            MEMWR:              v = c_ctrl_memwr;
            MEMWB:              v = c_ctrl_memwb;
            BRANCH:             v = c_ctrl_branch;
            default:            v = '0;
        endcase
        return v;
    endfunction

    // Counter width able to hold the timeout value itself
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_wait_timer
//  Description : Consecutive-stall counter for the control FSM wait states.
//                o_timeout flags that the current stall cycle is the last one
//                allowed; a stall in that cycle sends the FSM to FAULT.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_timeout
);

    localparam int                c_cnt_w = timer_width(WAIT_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WAIT_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // Stall counter: clear wins over increment, saturates at the last allowed value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm_v2.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm_v2
//  Description : Main control FSM of the multicycle ARM-subset core. Sequences
//                fetch/decode/execute/memory/writeback with stallable memory
//                states, a start/done long-op path, a stall watchdog and a
//                sticky FAULT state.
//  Revision    : 2.0 - stall support, long ops, watchdog, fault state
// ============================================================================
module mc_ctrl_fsm_v2
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16,
    parameter bit ENABLE_LONG  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       LongOp,
    input  logic       mem_ready,
    input  logic       ex_done,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ex_start,
    output logic       fault,
    output logic [3:0] state_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ex_first;
    logic                w_stall;
    logic                w_timeout;
    logic                w_clr;
    logic [CTRL_W-1:0]   w_ctrl;
    logic                w_unused_funct;

    // Funct[4:1] carries no control meaning here
    assign w_unused_funct = ^Funct[4:1];

    // A stall is a wait-state cycle whose completion condition is absent;
    // the first EXECUTEL cycle is the start cycle and never counts
    assign w_stall = (((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR)) && !mem_ready)
                   || ((r_state == EXECUTEL) && !r_ex_first && !ex_done);
    assign w_clr   = (w_state_nxt != r_state);

    mc_wait_timer #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_inc     (w_stall),
        .o_timeout (w_timeout)
    );

    // State register and first-cycle-of-EXECUTEL marker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_ex_first <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_first <= (w_state_nxt == EXECUTEL) && (r_state != EXECUTEL);
        end
    end

    // Next-state decode; a stall in the last allowed cycle overrides to FAULT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:    if (mem_ready) w_state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5])                  w_state_nxt = EXECUTEI;
                        else if (LongOp && ENABLE_LONG) w_state_nxt = EXECUTEL;
                        else                           w_state_nxt = EXECUTER;
                    end
                    2'b01:   w_state_nxt = MEMADR;
                    2'b10:   w_state_nxt = BRANCH;
                    default: w_state_nxt = FAULT;
                endcase
            end
            EXECUTER, EXECUTEI:    w_state_nxt = ALUWB;
            EXECUTEL: if (!r_ex_first && ex_done) w_state_nxt = ALUWB;
            MEMADR:                w_state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    if (mem_ready) w_state_nxt = MEMWB;
            MEMWR:    if (mem_ready) w_state_nxt = FETCH;
            ALUWB, MEMWB, BRANCH:  w_state_nxt = FETCH;
            FAULT:                 w_state_nxt = FAULT;
            default:               w_state_nxt = FAULT;
        endcase
        if (w_stall && w_timeout) begin
            w_state_nxt = FAULT;
        end
    end

    // Control outputs: per-state vector, memory-handshake gating, reset forces enables low
    always_comb begin
        w_ctrl = ctrl_for_state(r_state);
        if ((r_state == FETCH) && !mem_ready) begin
            w_ctrl[c_bit_nextpc]  = 1'b0;
            w_ctrl[c_bit_irwrite] = 1'b0;
        end
        if ((r_state == MEMWR) && !mem_ready) begin
            w_ctrl[c_bit_memw] = 1'b0;
        end
        if (!reset) begin
            w_ctrl[c_bit_nextpc:c_bit_irwrite] = '0;
        end
    end

    assign NextPC    = w_ctrl[12];
    assign Branch    = w_ctrl[11];
    assign MemW      = w_ctrl[10];
    assign RegW      = w_ctrl[9];
    assign IRWrite   = w_ctrl[8];
    assign AdrSrc    = w_ctrl[7];
    assign ResultSrc = w_ctrl[6:5];
    assign ALUSrcA   = w_ctrl[4:3];
    assign ALUSrcB   = w_ctrl[2:1];
    assign ALUOp     = w_ctrl[0];

    assign ex_start = reset && (r_state == EXECUTEL) && r_ex_first;
    assign fault    = (r_state == FAULT);
    assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_fsm_v2
//  Description : Directed self-checking bench for mc_ctrl_fsm_v2. Instance A
//                has long ops enabled, instance B has them disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm_v2;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                   S_EXECL = 10, S_FAULT = 11;

    localparam logic [12:0] V_FETCH  = 13'b1000101001100;
    localparam logic [12:0] V_DECODE = 13'b0000001001100;
    localparam logic [12:0] V_EXECR  = 13'b0000000000001;
    localparam logic [12:0] V_ALUWB  = 13'b0001000000000;
    localparam logic [12:0] V_MEMADR = 13'b0000000000010;
    localparam logic [12:0] V_MEMRD  = 13'b0000010000000;
    localparam logic [12:0] V_MEMWR  = 13'b0010010000000;
    localparam logic [12:0] V_MEMWB  = 13'b0001000100000;
    localparam logic [12:0] V_BRANCH = 13'b0100001000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       LongOp, mem_ready, ex_done;

    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ex_start, fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state_o;

    logic       b_IRWrite, b_AdrSrc, b_NextPC, b_RegW, b_MemW, b_Branch, b_ALUOp, b_ex_start, b_fault;
    logic [1:0] b_ALUSrcA, b_ALUSrcB, b_ResultSrc;
    logic [3:0] b_state_o;

    logic [12:0] ctrl;
    logic [5:0]  enables;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctrl    = {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
    assign enables = {NextPC, Branch, MemW, RegW, IRWrite, ex_start};

    mc_ctrl_fsm_v2 #(.WAIT_TIMEOUT(16), .ENABLE_LONG(1'b1)) dut_a (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .LongOp(LongOp),
        .mem_ready(mem_ready), .ex_done(ex_done),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ex_start(ex_start), .fault(fault), .state_o(state_o)
    );

    mc_ctrl_fsm_v2 #(.WAIT_TIMEOUT(16), .ENABLE_LONG(1'b0)) dut_b (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .LongOp(LongOp),
        .mem_ready(mem_ready), .ex_done(ex_done),
        .IRWrite(b_IRWrite), .AdrSrc(b_AdrSrc), .NextPC(b_NextPC), .RegW(b_RegW), .MemW(b_MemW),
        .Branch(b_Branch), .ALUOp(b_ALUOp), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .ResultSrc(b_ResultSrc), .ex_start(b_ex_start), .fault(b_fault), .state_o(b_state_o)
    );

    // Reset for one cycle, release on a falling edge with the FSM in FETCH
    task automatic apply_reset();
        reset = 1'b0; mem_ready = 1'b1; ex_done = 1'b0; LongOp = 1'b0;
        Op = 2'b00; Funct = 6'b000000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; ex_done = 1'b0; LongOp = 1'b0;
        Op = 2'b00; Funct = 6'b000000;
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_FETCH)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, S_FETCH); end
        checks++; if (enables !== 6'b0) begin failures++; $display("FAIL reset_enables got=%b exp=000000", enables); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
        @(negedge clk);
        reset = 1'b1; #1;
        checks++; if (ctrl !== V_FETCH) begin failures++; $display("FAIL reset_release_ctrl got=%b exp=%b", ctrl, V_FETCH); end
    endtask

    task automatic test_add();
        int          exp_st[5] = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        logic [12:0] exp_c[4]  = '{V_FETCH, V_DECODE, V_EXECR, V_ALUWB};
        int          regw_cnt  = 0;
        apply_reset();
        Op = 2'b00; Funct = 6'b000100; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state_o !== 4'(exp_st[i])) begin failures++; $display("FAIL add_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
            if (i < 4) begin
                checks++; if (ctrl !== exp_c[i]) begin failures++; $display("FAIL add_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_c[i]); end
                if (RegW === 1'b1) regw_cnt++;
            end
            @(negedge clk);
        end
        checks++; if (regw_cnt != 1) begin failures++; $display("FAIL add_regw_count got=%0d exp=1", regw_cnt); end
    endtask

    task automatic test_ldr();
        logic        rdy[9]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          exp_st[9] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
        logic [12:0] exp_c[8]  = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        int          regw_cnt  = 0;
        apply_reset();
        Op = 2'b01; Funct = 6'b011001;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i]; #1;
            checks++; if (state_o !== 4'(exp_st[i])) begin failures++; $display("FAIL ldr_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
            if (i < 8) begin
                checks++; if (ctrl !== exp_c[i]) begin failures++; $display("FAIL ldr_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_c[i]); end
                if (RegW === 1'b1) regw_cnt++;
            end
            @(negedge clk);
        end
        checks++; if (regw_cnt != 1) begin failures++; $display("FAIL ldr_regw_count got=%0d exp=1", regw_cnt); end
    endtask

    task automatic test_str();
        logic        rdy[7]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          exp_st[7] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR, S_FETCH};
        logic [12:0] exp_c[6]  = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMWR};
        int          memw_cnt  = 0;
        apply_reset();
        Op = 2'b01; Funct = 6'b011000;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i]; #1;
            checks++; if (state_o !== 4'(exp_st[i])) begin failures++; $display("FAIL str_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
            if (i < 6) begin
                checks++; if (ctrl !== exp_c[i]) begin failures++; $display("FAIL str_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_c[i]); end
                if (MemW === 1'b1) memw_cnt++;
            end
            @(negedge clk);
        end
        checks++; if (memw_cnt != 1) begin failures++; $display("FAIL str_memw_count got=%0d exp=1", memw_cnt); end
    endtask

    task automatic test_branch();
        int          exp_st[4] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        logic [12:0] exp_c[3]  = '{V_FETCH, V_DECODE, V_BRANCH};
        apply_reset();
        Op = 2'b10; Funct = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state_o !== 4'(exp_st[i])) begin failures++; $display("FAIL b_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
            if (i < 3) begin
                checks++; if (ctrl !== exp_c[i]) begin failures++; $display("FAIL b_ctrl[%0d] got=%b exp=%b", i, ctrl, exp_c[i]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_long();
        // EXECUTEL cycles: start (ex_done=1 must be ignored), four waits, then done
        logic done_seq[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   start_cnt   = 0;
        apply_reset();
        Op = 2'b00; Funct = 6'b000000; LongOp = 1'b1; mem_ready = 1'b1;
        #1;
        checks++; if (state_o !== 4'(S_FETCH)) begin failures++; $display("FAIL long_fetch got=%0d exp=%0d", state_o, S_FETCH); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_DECODE)) begin failures++; $display("FAIL long_decode got=%0d exp=%0d", state_o, S_DECODE); end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ex_done = done_seq[i]; #1;
            checks++; if (state_o !== 4'(S_EXECL)) begin failures++; $display("FAIL long_state[%0d] got=%0d exp=%0d", i, state_o, S_EXECL); end
            checks++; if (ex_start !== (i == 0)) begin failures++; $display("FAIL long_ex_start[%0d] got=%b exp=%b", i, ex_start, (i == 0)); end
            if (ex_start === 1'b1) start_cnt++;
            if (i == 0) begin
                checks++; if (ctrl !== V_EXECR) begin failures++; $display("FAIL long_ctrl got=%b exp=%b", ctrl, V_EXECR); end
                checks++; if (b_state_o !== 4'(S_EXECR)) begin failures++; $display("FAIL nolong_state got=%0d exp=%0d", b_state_o, S_EXECR); end
                checks++; if (b_ex_start !== 1'b0) begin failures++; $display("FAIL nolong_ex_start got=%b exp=0", b_ex_start); end
            end
            @(negedge clk);
        end
        ex_done = 1'b0; #1;
        checks++; if (state_o !== 4'(S_ALUWB)) begin failures++; $display("FAIL long_aluwb got=%0d exp=%0d", state_o, S_ALUWB); end
        checks++; if (RegW !== 1'b1) begin failures++; $display("FAIL long_regw got=%b exp=1", RegW); end
        checks++; if (start_cnt != 1) begin failures++; $display("FAIL long_start_count got=%0d exp=1", start_cnt); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_FETCH)) begin failures++; $display("FAIL long_return got=%0d exp=%0d", state_o, S_FETCH); end
        LongOp = 1'b0;
    endtask

    task automatic test_timeout();
        int irw_cnt = 0;
        apply_reset();
        Op = 2'b10; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (state_o !== 4'(S_FETCH)) begin failures++; $display("FAIL to_stall_state[%0d] got=%0d exp=%0d", i, state_o, S_FETCH); end
            if (IRWrite !== 1'b0) irw_cnt++;
            @(negedge clk);
        end
        #1;
        checks++; if (irw_cnt != 0) begin failures++; $display("FAIL to_irwrite_count got=%0d exp=0", irw_cnt); end
        checks++; if (state_o !== 4'(S_FAULT)) begin failures++; $display("FAIL to_fault_state got=%0d exp=%0d", state_o, S_FAULT); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL to_fault_flag got=%b exp=1", fault); end
        checks++; if (ctrl !== 13'b0) begin failures++; $display("FAIL to_fault_ctrl got=%b exp=0", ctrl); end
        mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_FAULT)) begin failures++; $display("FAIL to_sticky got=%0d exp=%0d", state_o, S_FAULT); end

        // Ready in the last allowed stall cycle wins over the watchdog
        apply_reset();
        Op = 2'b10; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        mem_ready = 1'b1; #1;
        checks++; if (IRWrite !== 1'b1) begin failures++; $display("FAIL to_edge_irwrite got=%b exp=1", IRWrite); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_DECODE)) begin failures++; $display("FAIL to_edge_state got=%0d exp=%0d", state_o, S_DECODE); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL to_edge_fault got=%b exp=0", fault); end
    endtask

    task automatic test_undef_and_abort();
        apply_reset();
        Op = 2'b11; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_FAULT)) begin failures++; $display("FAIL undef_state got=%0d exp=%0d", state_o, S_FAULT); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL undef_fault got=%b exp=1", fault); end

        // Reset asserted in the middle of a store wait
        apply_reset();
        Op = 2'b01; Funct = 6'b000000; mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_MEMWR)) begin failures++; $display("FAIL abort_pre_state got=%0d exp=%0d", state_o, S_MEMWR); end
        mem_ready = 1'b1; reset = 1'b0; #1;
        checks++; if (state_o !== 4'(S_FETCH)) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", state_o, S_FETCH); end
        checks++; if (enables !== 6'b0) begin failures++; $display("FAIL abort_enables got=%b exp=000000", enables); end
        @(negedge clk); #1;
        checks++; if (enables !== 6'b0) begin failures++; $display("FAIL abort_hold_enables got=%b exp=000000", enables); end
        reset = 1'b1; #1;
        checks++; if (ctrl !== V_FETCH) begin failures++; $display("FAIL abort_release_ctrl got=%b exp=%b", ctrl, V_FETCH); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL abort_fault got=%b exp=0", fault); end
        @(negedge clk); #1;
        checks++; if (state_o !== 4'(S_DECODE)) begin failures++; $display("FAIL abort_resume got=%0d exp=%0d", state_o, S_DECODE); end
    endtask

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'b0; LongOp = 1'b0; mem_ready = 1'b0; ex_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_ldr();
        test_str();
        test_branch();
        test_long();
        test_timeout();
        test_undef_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
